mem_access_arbiter: RTL
=======================

Name: mem_access_arbiter

Overview:
Shared-access controller for the 16-bit single-port RAM used by the CPU and the switch/button front panel. It arbitrates between a CPU requester and a panel requester using round-robin order. It sequences each access into one RAM cycle and returns read data with a one-cycle ack. After reset or on request, it runs a clear sequence that zero-fills the RAM before any other access is served.

Parameters:
ADDR_W, 15, address width in bits
DATA_W, 16, data word width in bits
DEPTH, 1024, number of implemented RAM words; addresses >= DEPTH are out of range
CLEAR_EN, 1, 1 = run the clear sequence after reset; 0 = go straight to IDLE after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
init_start  in  1  single-cycle pulse: request a RAM clear sequence
cpu_req  in  1  CPU access request; held high until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  valid with cpu_ack: address out of range
cpu_rdata  out  DATA_W  read data, valid from cpu_ack onward
pnl_req, pnl_we, pnl_addr, pnl_wdata  in  1/1/ADDR_W/DATA_W  panel requester, same semantics as cpu_*
pnl_ack, pnl_err, pnl_rdata  out  1/1/DATA_W  panel responses, same semantics as cpu_*
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data; synchronous, valid the cycle after address is presented
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): all outputs 0; clr_ptr=0; last_grant=PNL, so the CPU wins the first tie; init_pending=0. On release, state is CLEAR if CLEAR_EN=1, otherwise IDLE.
- States: CLEAR, IDLE, ACCESS, RDWAIT, ACK.
- CLEAR: each cycle drive mem_we=1, mem_addr=clr_ptr, mem_wdata=0, then increment clr_ptr. After writing DEPTH-1, go to IDLE. Requests are held off (no ack). An init_start pulse in CLEAR resets clr_ptr to 0, so a full DEPTH-cycle clear restarts.
- IDLE:
  - If init_pending or init_start is set: go to CLEAR with clr_ptr=0 and clear init_pending. This takes priority over requests.
  - Otherwise, if exactly one req is high: grant it.
  - If both are high: grant the requester that is not last_grant.
  - On grant: register we/addr/wdata and the owner, update last_grant, go to ACCESS.
- ACCESS (1 cycle):
  - In-range address: mem_addr = registered address.
  - Write: mem_we=1 and mem_wdata = registered data; next state ACK.
  - Read: mem_we=0; next state RDWAIT.
  - Out-of-range address (>= DEPTH): mem_we forced to 0 and no RAM effect; next state ACK with err=1.
- RDWAIT (1 cycle): capture mem_rdata into the owner's rdata register; next state ACK.
- ACK (1 cycle): owner's ack=1 and err as determined; next state IDLE. The non-owner's rdata is untouched. After an error or a write, the owner's rdata keeps its previous value.
- Latency, with req first sampled in IDLE at edge N:
  - Write: ack high in cycle N+2.
  - Read: ack high in cycle N+3.
  - Out-of-range: ack high in cycle N+2.
- An init_start pulse in ACCESS, RDWAIT or ACK sets init_pending. The current transaction completes normally, then CLEAR begins.
- A req dropped before it is granted is ignored. A req still high in the IDLE cycle after ack is treated as a new request; round-robin then favours the other requester if it is also pending.
- When idle: mem_we=0, while mem_addr and mem_wdata hold their last values.
- Reset asserted mid-transaction aborts it with no ack. The clear sequence reruns after reset if CLEAR_EN=1.

Test Plan:
1. Reset with CLEAR_EN=1, DEPTH=1024 -> busy=1 for exactly 1024 cycles, mem_we=1 with mem_addr stepping 0..1023, mem_wdata=0; then IDLE with busy=0.
2. CPU write addr=3, data=0x5555, then CPU read addr=3 -> write ack 2 cycles after req is seen; read ack 3 cycles after req is seen; cpu_rdata=0x5555, err=0.
3. cpu_req and pnl_req raised in the same cycle, held and re-raised 4 times -> grants alternate CPU, PNL, CPU, PNL; no cycle has both acks high.
4. Panel read addr=1024 (DEPTH=1024) -> pnl_ack with pnl_err=1, mem_we=0 throughout, pnl_rdata unchanged.
5. init_start pulsed during the ACCESS cycle of a CPU write to addr=2, data=0x0F0F -> cpu_ack is delivered, then the full clear runs; a read of addr 2 afterwards returns 0x0000.
6. rst_n pulled low during RDWAIT of a panel read -> all outputs go to 0 immediately, no pnl_ack, and the clear sequence restarts when rst_n returns high.

Source files
------------

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter giving the CPU and the front panel shared access to a
// single-port synchronous RAM, with a zero-fill sequence after reset or on demand.
module mem_access_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 1024,
  parameter int CLEAR_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              pnl_req,
  input  logic              pnl_we,
  input  logic [ADDR_W-1:0] pnl_addr,
  input  logic [DATA_W-1:0] pnl_wdata,
  output logic              pnl_ack,
  output logic              pnl_err,
  output logic [DATA_W-1:0] pnl_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [2:0] S_CLEAR  = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_RDWAIT = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;

  localparam logic [2:0]        RESET_STATE = (CLEAR_EN != 0) ? S_CLEAR : S_IDLE;
  localparam logic [ADDR_W:0]   DEPTH_W     = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic              started;
  logic [ADDR_W-1:0] clr_ptr;
  logic              init_pending;
  logic              last_pnl;
  logic              owner_pnl;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;

  logic              addr_ok;
  logic              grant_pnl;
  logic              any_req;

  assign addr_ok   = ({1'b0, req_addr} < DEPTH_W);
  assign any_req   = cpu_req | pnl_req;
  assign grant_pnl = (cpu_req & pnl_req) ? ~last_pnl : pnl_req;

  // started stays low for the first cycle after reset release so outputs are
  // all zero while rst_n is asserted, even though state already sits in CLEAR.
  assign busy    = started && (state != S_IDLE);
  assign cpu_ack = (state == S_ACK) && !owner_pnl;
  assign pnl_ack = (state == S_ACK) && owner_pnl;
  assign cpu_err = cpu_ack && !addr_ok;
  assign pnl_err = pnl_ack && !addr_ok;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_hold;
    mem_wdata = wdata_hold;
    if (started) begin
      case (state)
        S_CLEAR: begin
          mem_we    = 1'b1;
          mem_addr  = clr_ptr;
          mem_wdata = '0;
        end
        S_ACCESS: begin
          if (addr_ok) begin
            mem_addr = req_addr;
            if (req_we) begin
              mem_we    = 1'b1;
              mem_wdata = req_wdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      addr_hold  <= mem_addr;
      wdata_hold <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RESET_STATE;
      started      <= 1'b0;
      clr_ptr      <= '0;
      init_pending <= 1'b0;
      last_pnl     <= 1'b1;
      owner_pnl    <= 1'b0;
      req_we       <= 1'b0;
      req_addr     <= '0;
      req_wdata    <= '0;
      cpu_rdata    <= '0;
      pnl_rdata    <= '0;
    end else if (!started) begin
      started <= 1'b1;
    end else begin
      // A clear request arriving mid-transaction is remembered and served next.
      if (init_start && (state == S_ACCESS || state == S_RDWAIT || state == S_ACK))
        init_pending <= 1'b1;
      case (state)
        S_CLEAR: begin
          if (init_start) begin
            clr_ptr <= '0;
          end else if (clr_ptr == LAST_ADDR) begin
            clr_ptr <= '0;
            state   <= S_IDLE;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        S_IDLE: begin
          if (init_pending || init_start) begin
            init_pending <= 1'b0;
            clr_ptr      <= '0;
            state        <= S_CLEAR;
          end else if (any_req) begin
            owner_pnl <= grant_pnl;
            last_pnl  <= grant_pnl;
            req_we    <= grant_pnl ? pnl_we    : cpu_we;
            req_addr  <= grant_pnl ? pnl_addr  : cpu_addr;
            req_wdata <= grant_pnl ? pnl_wdata : cpu_wdata;
            state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          state <= (req_we || !addr_ok) ? S_ACK : S_RDWAIT;
        end
        S_RDWAIT: begin
          if (owner_pnl) pnl_rdata <= mem_rdata;
          else           cpu_rdata <= mem_rdata;
          state <= S_ACK;
        end
        S_ACK: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
